fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-request-at-a-time fetch from instruction memory,
// a valid/ready hand-off to decode, and PC redirection for jumps, branches and halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_insn,
  output logic [15:0] dec_pc,
  input  logic        br_resolve,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  // Decode handshake: the word transfers on any rising edge where dec_valid && dec_ready;
  // dec_insn/dec_pc hold steady while dec_valid is high and dec_ready is low.

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_BR_WAIT = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] insn_q, ipc_q;
  logic        load_insn;
  logic [15:0] rel_off;

  assign rel_off = {{4{insn_q[11]}}, insn_q[11:0]};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_insn = 1'b0;
    case (state)
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          load_insn = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dec_ready) begin
          if (insn_q == 16'h0000) begin
            state_nxt = ST_HALTED;
          end else if (insn_q[15:14] == 2'b01) begin
            if (insn_q[13]) begin
              state_nxt = ST_BR_WAIT;
            end else begin
              pc_nxt    = insn_q[12] ? (pc + rel_off) : {4'b0000, insn_q[11:0]};
              state_nxt = ST_FETCH;
            end
          end else begin
            pc_nxt    = pc + 16'd1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_BR_WAIT: begin
        if (br_resolve) begin
          pc_nxt    = br_taken ? br_target : (pc + 16'd1);
          state_nxt = ST_FETCH;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      insn_q <= 16'h0001;
      ipc_q  <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load_insn) begin
        insn_q <= imem_rdata;
        ipc_q  <= pc;
      end
    end
  end

  // Gating with rst_n keeps the request low while reset is held in the FETCH state.
  assign imem_req  = rst_n && (state == ST_FETCH);
  assign imem_addr = pc;
  assign dec_valid = (state == ST_ISSUE);
  assign dec_insn  = insn_q;
  assign dec_pc    = ipc_q;
  assign halted    = (state == ST_HALTED);
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized programs, memory latency,
// decode back-pressure and branch resolution, checked against an instruction-level model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        dec_ready;
  logic        br_resolve;
  logic        br_taken;
  logic [15:0] br_target;

  logic        req_a, dv_a, hl_a, req_b, dv_b, hl_b;
  logic [15:0] addr_a, insn_a, pc_a, addr_b, insn_b, pc_b;
  logic [2:0]  st_a, st_b;

  fetch_unit #(.RESET_PC(16'h0000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .imem_req(req_a), .imem_addr(addr_a),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dv_a),
    .dec_ready(dec_ready), .dec_insn(insn_a), .dec_pc(pc_a), .br_resolve(br_resolve),
    .br_taken(br_taken), .br_target(br_target), .halted(hl_a), .dbg_state(st_a)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dv_b),
    .dec_ready(dec_ready), .dec_insn(insn_b), .dec_pc(pc_b), .br_resolve(br_resolve),
    .br_taken(br_taken), .br_target(br_target), .halted(hl_b), .dbg_state(st_b)
  );

  // The instance under observation; both see the same stimulus.
  logic        sel;
  logic        o_req, o_dv, o_halt;
  logic [15:0] o_addr, o_insn, o_pc;
  assign o_req  = sel ? req_b  : req_a;
  assign o_dv   = sel ? dv_b   : dv_a;
  assign o_halt = sel ? hl_b   : hl_a;
  assign o_addr = sel ? addr_b : addr_a;
  assign o_insn = sel ? insn_b : insn_a;
  assign o_pc   = sel ? pc_b   : pc_a;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] prog [logic [15:0]];
  logic [15:0] req_log[$];
  logic [15:0] pc_log[$];
  logic [15:0] exp_q[$];

  logic [15:0] m_pc, pend_addr, exp_insn;
  bit          m_halted, exp_req, exp_issue, pending, in_br, rv_now;
  int          lat, br_cnt, hold_cnt, halt_cnt, n_req;

  int          k_lat_max, k_ready_pct, k_hold, k_spur_pct, k_br_mode, k_rst_req;
  bit          k_br_taken;
  logic [15:0] k_br_target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_log(input string tag, input logic [15:0] got[$], input logic [15:0] want[$]);
    check({tag, " len"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? {16'h0, got[i]} : 32'hFFFF_FFFF,
            {16'h0, want[i]});
  endtask

  function automatic logic [15:0] gen_word();
    logic [15:0] w;
    int r;
    w = 16'($urandom);
    r = $urandom_range(0, 99);
    if (r < 3) w = 16'h0000;
    else if (r < 20) w[15:13] = 3'b010;
    else if (r < 35) w[15:13] = 3'b011;
    else begin
      if (w[15:14] == 2'b01) w[15:14] = 2'b11;
      if (w == 16'h0000) w = 16'h0001;
    end
    return w;
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (!prog.exists(a)) prog[a] = gen_word();
    return prog[a];
  endfunction

  // Instruction semantics in plain integer arithmetic modulo 65536.
  function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [15:0] w);
    int off;
    if (w[15:14] == 2'b01 && !w[13]) begin
      if (w[12]) begin
        off = w[11] ? int'(w[11:0]) - 4096 : int'(w[11:0]);
        return 16'((int'(pc) + off + 65536) % 65536);
      end
      return 16'(int'(w[11:0]));
    end
    return 16'((int'(pc) + 1) % 65536);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0; dec_ready = 1'b0;
    br_resolve = 1'b0; br_taken = 1'b0; br_target = 16'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst imem_req", o_req, 0);
    check("rst imem_addr", o_addr, sel ? 16'hFFFF : 16'h0000);
    check("rst dec_valid", o_dv, 0);
    check("rst dec_insn", o_insn, 16'h0001);
    check("rst dec_pc", o_pc, 16'h0000);
    check("rst halted", o_halt, 0);
    m_pc = sel ? 16'hFFFF : 16'h0000;
    exp_req = 1; pending = 0; exp_issue = 0; in_br = 0; m_halted = 0;
    halt_cnt = 0; n_req = 0; br_cnt = 0; hold_cnt = 0;
  endtask

  task automatic run(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk); #1;
      if (k_rst_req != 0 && n_req == k_rst_req && pending) begin
        k_rst_req = 0;
        do_reset();
        continue;
      end
      rst_n = 1'b1;
      rv_now = 0;
      imem_rvalid = 1'b0;
      imem_rdata = 16'($urandom);
      if (pending) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr); pending = 0; rv_now = 1;
        end else lat--;
      end else if ($urandom_range(0, 99) < k_spur_pct) imem_rvalid = 1'b1;
      if (exp_issue && hold_cnt < k_hold) begin
        dec_ready = 1'b0; hold_cnt++;
      end else dec_ready = ($urandom_range(0, 99) < k_ready_pct);
      br_resolve = 1'b0; br_taken = 1'($urandom); br_target = 16'($urandom);
      if (k_br_mode == 1) begin
        if (exp_issue) begin
          br_resolve = 1'b1; br_taken = 1'b1;
        end else if (in_br) begin
          br_cnt++;
          if (br_cnt == 3) begin
            br_resolve = 1'b1; br_taken = k_br_taken; br_target = k_br_target;
          end
        end
      end else if (k_br_mode == 2) br_resolve = ($urandom_range(0, 3) == 0);

      @(negedge clk);
      check("imem_req", o_req, exp_req);
      if (exp_req) begin
        check("imem_addr", o_addr, m_pc);
        req_log.push_back(o_addr);
        pend_addr = m_pc; pending = 1; lat = $urandom_range(0, k_lat_max); n_req++;
        exp_req = 0;
      end
      check("dec_valid", o_dv, exp_issue);
      check("halted", o_halt, m_halted);
      if (exp_issue) begin
        check("dec_insn", o_insn, exp_insn);
        check("dec_pc", o_pc, m_pc);
        if (dec_ready) begin
          pc_log.push_back(o_pc);
          exp_issue = 0;
          if (exp_insn == 16'h0000) m_halted = 1;
          else if (exp_insn[15:13] == 3'b011) begin
            in_br = 1; br_cnt = 0;
          end else begin
            m_pc = next_pc(m_pc, exp_insn); exp_req = 1;
          end
        end
      end else if (in_br && br_resolve) begin
        m_pc = br_taken ? br_target : m_pc + 16'd1;
        in_br = 0; exp_req = 1;
      end
      if (rv_now) begin
        exp_issue = 1; exp_insn = imem_rdata; hold_cnt = 0;
      end
      if (m_halted) halt_cnt++;
      if (halt_cnt > 6) break;
    end
  endtask

  task automatic start_test(input bit s);
    sel = s;
    prog.delete(); req_log.delete(); pc_log.delete();
    k_lat_max = 0; k_ready_pct = 100; k_hold = 0; k_spur_pct = 0; k_br_mode = 0;
    k_rst_req = 0; k_br_taken = 0; k_br_target = 16'h0;
    @(posedge clk); #1;
    do_reset();
  endtask

  initial begin
    sel = 1'b0;
    do_reset();

    // Sequential SET, operation, then HLT from address 0.
    start_test(0);
    prog[16'h0000] = 16'h8000; prog[16'h0001] = 16'h2000; prog[16'h0002] = 16'h0000;
    run(60);
    exp_q = '{16'h0000, 16'h0001, 16'h0002};
    check_log("seq req", req_log, exp_q);
    check_log("seq pc", pc_log, exp_q);
    check("seq halted", o_halt, 1);

    // Relative jump backwards by 2 from 0x0010.
    start_test(0);
    prog[16'h0000] = 16'h4010; prog[16'h0010] = 16'h5FFE; prog[16'h000E] = 16'h0000;
    run(60);
    exp_q = '{16'h0000, 16'h0010, 16'h000E};
    check_log("rel req", req_log, exp_q);

    // Absolute jump from 0x0010.
    start_test(0);
    prog[16'h0000] = 16'h4010; prog[16'h0010] = 16'h4123; prog[16'h0123] = 16'h0000;
    run(60);
    exp_q = '{16'h0000, 16'h0010, 16'h0123};
    check_log("abs req", req_log, exp_q);

    // Branch taken, with an ignored resolve pulse in the handshake cycle.
    start_test(0);
    prog[16'h0000] = 16'h4020; prog[16'h0020] = 16'h6000; prog[16'h0100] = 16'h0000;
    k_br_mode = 1; k_br_taken = 1; k_br_target = 16'h0100;
    run(60);
    exp_q = '{16'h0000, 16'h0020, 16'h0100};
    check_log("br_t req", req_log, exp_q);

    // Branch not taken.
    start_test(0);
    prog[16'h0000] = 16'h4020; prog[16'h0020] = 16'h6000; prog[16'h0021] = 16'h0000;
    k_br_mode = 1; k_br_taken = 0; k_br_target = 16'h0100;
    run(60);
    exp_q = '{16'h0000, 16'h0020, 16'h0021};
    check_log("br_nt req", req_log, exp_q);

    // Decode stall for 5 cycles with spurious read-data pulses.
    start_test(0);
    prog[16'h0000] = 16'h8000; prog[16'h0001] = 16'h0000;
    k_hold = 5; k_spur_pct = 100;
    run(60);
    exp_q = '{16'h0000, 16'h0001};
    check_log("stall req", req_log, exp_q);
    check_log("stall pc", pc_log, exp_q);

    // Wrap from 0xFFFF, then reset while waiting on memory.
    start_test(1);
    prog[16'hFFFF] = 16'h8000; prog[16'h0000] = 16'h0000;
    k_rst_req = 2;
    run(80);
    exp_q = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    check_log("wrap req", req_log, exp_q);
    exp_q = '{16'hFFFF, 16'hFFFF, 16'h0000};
    check_log("wrap pc", pc_log, exp_q);
    check("wrap halted", o_halt, 1);

    // Randomized programs, latency, back-pressure and branch outcomes.
    for (int t = 0; t < 40; t++) begin
      start_test(1'($urandom_range(0, 1)));
      k_lat_max = $urandom_range(0, 3);
      k_ready_pct = $urandom_range(30, 100);
      k_hold = $urandom_range(0, 3);
      k_spur_pct = $urandom_range(0, 50);
      k_br_mode = 2;
      k_rst_req = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
      run(400);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
